// File: rtl/axi_wr_addr_master_pkg.sv
// Shared types and default geometry for the AXI write-address master.
// Request record stored in the FIFO, FSM state encoding and default channel widths.
package axi_aw_pkg;

  localparam int AW_ID_W       = 4;
  localparam int AW_ADDR_W     = 32;
  localparam int AW_LEN_W      = 4;
  localparam int AW_BEAT_BYTES = 4;
  localparam int AW_BOUNDARY   = 4096;

  typedef struct packed {
    logic [AW_ID_W-1:0]   id;
    logic [AW_ADDR_W-1:0] addr;
    logic [AW_LEN_W-1:0]  len;
  } aw_req_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    ISSUE2
  } aw_state_t;

endpackage

// File: rtl/axi_wr_addr_master_if.sv
// AXI write-address channel bundle with master and slave views.
interface axi_wr_addr_intf
  import axi_aw_pkg::*;
#(
  parameter int ID_W   = AW_ID_W,
  parameter int ADDR_W = AW_ADDR_W,
  parameter int LEN_W  = AW_LEN_W
) ();

  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [LEN_W-1:0]  awlen;
  logic              awvalid;
  logic              awready;

  modport MASTER (output awid, awaddr, awlen, awvalid, input awready);
  modport SLAVE  (input awid, awaddr, awlen, awvalid, output awready);

endinterface

// File: rtl/axi_wr_addr_master_sync_fifo.sv
// Single-clock FIFO; pointers carry one extra MSB so full and empty are distinguishable.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wrPtr_q, rdPtr_q;
  logic [PTR_W:0]   count;
  logic             doPush, doPop;

  assign count   = wrPtr_q - rdPtr_q;
  assign full_o  = (count == (PTR_W+1)'(DEPTH));
  assign empty_o = (wrPtr_q == rdPtr_q);
  assign count_o = count;
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign data_o  = mem_q[rdPtr_q[PTR_W-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q[PTR_W-1:0]] <= data_i;
  end

endmodule

// File: rtl/axi_wr_addr_master.sv
// AXI write-address master: queues requests, splits boundary-crossing bursts,
// and issues them on the AW channel with registered valid and a handshake counter.
module axi_wr_addr_master
  import axi_aw_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W       = AW_ID_W,
  parameter int ADDR_W     = AW_ADDR_W,
  parameter int LEN_W      = AW_LEN_W,
  parameter int BEAT_BYTES = AW_BEAT_BYTES,
  parameter int BOUNDARY   = AW_BOUNDARY
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [ID_W-1:0]               req_id_i,
  input  logic [ADDR_W-1:0]             req_addr_i,
  input  logic [LEN_W-1:0]              req_len_i,
  axi_wr_addr_intf.MASTER               aw,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          busy_o,
  output logic [15:0]                   issue_cnt_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OFF_W = $clog2(BOUNDARY);
  localparam int BB_W  = $clog2(BEAT_BYTES);
  localparam int SUM_W = OFF_W + LEN_W + BB_W + 2;

  aw_req_t           pushReq, headReq;
  logic              fifoFull, fifoEmpty, fifoPush, fifoPop;
  logic [CNT_W-1:0]  fifoCount;

  aw_state_t         state_q, state_d;
  logic              awValid_q, awValid_d;
  logic [ID_W-1:0]   awId_q, awId_d;
  logic [ADDR_W-1:0] awAddr_q, awAddr_d;
  logic [LEN_W-1:0]  awLen_q, awLen_d;
  logic              splitPend_q, splitPend_d;
  logic [ADDR_W-1:0] pendAddr_q, pendAddr_d;
  logic [LEN_W-1:0]  pendLen_q, pendLen_d;
  logic [15:0]       issueCnt_q, issueCnt_d;

  logic              hs, loadHead, needSplit;
  logic [SUM_W-1:0]  offExt, bytesExt, firstBeats;
  logic [LEN_W-1:0]  firstLen, secondLen;
  logic [ADDR_W-1:0] secondAddr;

  always_comb begin
    pushReq.id   = req_id_i;
    pushReq.addr = req_addr_i & ~ADDR_W'(BEAT_BYTES - 1);
    pushReq.len  = req_len_i;
  end

  assign req_ready_o = !fifoFull;
  assign fifoPush    = req_valid_i && !fifoFull;

  sync_fifo #(
    .WIDTH ($bits(aw_req_t)),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifoPush),
    .data_i  (pushReq),
    .pop_i   (fifoPop),
    .data_o  (headReq),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  // Widened arithmetic so offset + burst bytes cannot overflow before the compare.
  always_comb begin
    offExt     = SUM_W'(headReq.addr[OFF_W-1:0]);
    bytesExt   = (SUM_W'(headReq.len) + SUM_W'(1)) << BB_W;
    needSplit  = (offExt + bytesExt) > SUM_W'(BOUNDARY);
    firstBeats = (SUM_W'(BOUNDARY) - offExt) >> BB_W;
    firstLen   = LEN_W'(firstBeats - SUM_W'(1));
    secondLen  = LEN_W'(SUM_W'(headReq.len) - firstBeats);
    secondAddr = (headReq.addr | ADDR_W'(BOUNDARY - 1)) + ADDR_W'(1);
  end

  assign hs = awValid_q && aw.awready;

  always_comb begin
    state_d     = state_q;
    awValid_d   = awValid_q;
    awId_d      = awId_q;
    awAddr_d    = awAddr_q;
    awLen_d     = awLen_q;
    splitPend_d = splitPend_q;
    pendAddr_d  = pendAddr_q;
    pendLen_d   = pendLen_q;
    fifoPop     = 1'b0;
    loadHead    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifoEmpty) begin
          loadHead = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (hs) begin
          if (splitPend_q) begin
            awAddr_d    = pendAddr_q;
            awLen_d     = pendLen_q;
            splitPend_d = 1'b0;
            state_d     = ISSUE2;
          end else if (!fifoEmpty) begin
            loadHead = 1'b1;
          end else begin
            awValid_d = 1'b0;
            state_d   = IDLE;
          end
        end
      end
      ISSUE2: begin
        if (hs) begin
          if (!fifoEmpty) begin
            loadHead = 1'b1;
            state_d  = ISSUE;
          end else begin
            awValid_d = 1'b0;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A load keeps awvalid high, so back-to-back bursts leave no bubble.
    if (loadHead) begin
      fifoPop     = 1'b1;
      awValid_d   = 1'b1;
      awId_d      = headReq.id;
      awAddr_d    = headReq.addr;
      awLen_d     = needSplit ? firstLen : headReq.len;
      splitPend_d = needSplit;
      pendAddr_d  = secondAddr;
      pendLen_d   = secondLen;
    end

    issueCnt_d = hs ? issueCnt_q + 16'd1 : issueCnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      awValid_q   <= 1'b0;
      awId_q      <= '0;
      awAddr_q    <= '0;
      awLen_q     <= '0;
      splitPend_q <= 1'b0;
      pendAddr_q  <= '0;
      pendLen_q   <= '0;
      issueCnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      awValid_q   <= awValid_d;
      awId_q      <= awId_d;
      awAddr_q    <= awAddr_d;
      awLen_q     <= awLen_d;
      splitPend_q <= splitPend_d;
      pendAddr_q  <= pendAddr_d;
      pendLen_q   <= pendLen_d;
      issueCnt_q  <= issueCnt_d;
    end
  end

  assign aw.awid      = awId_q;
  assign aw.awaddr    = awAddr_q;
  assign aw.awlen     = awLen_q;
  assign aw.awvalid   = awValid_q;
  assign fifo_count_o = fifoCount;
  assign busy_o       = (state_q != IDLE) || (fifoCount != '0);
  assign issue_cnt_o  = issueCnt_q;

endmodule
